led_frame_sequencer: RTL
========================

// Module: led_frame_sequencer
// PURPOSE
//  Sequences one refresh of the serial LED strip. Walks the pixel byte store written by the I2C
//  register slave, feeds bytes one at a time to the single-wire bit encoder that drives led_o,
//  waits for the last bit to drain, then holds the latch gap. Sits between the register file and
//  the encoder, inside the LED controller top level.
// PARAMETERS
//  LED_CNT         10      number of LEDs on the strip
//  BYTES_PER_LED   3       colour bytes per LED (G,R,B order as stored)
//  LATCH_CYCLES    3000    clk cycles of idle line after the last bit (>=280 us at 10 MHz)
//  REFRESH_CYCLES  500000  auto-refresh period in clk cycles (used only with AUTO_REFRESH_EN)
//  Derived: NBYTES = LED_CNT*BYTES_PER_LED; AW = $clog2(NBYTES)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous reset, active high
//  upd_req_i    in   1   one-cycle request: refresh the strip from the pixel store
//  rd_en_o      out  1   pixel store read enable
//  rd_addr_o    out  AW  pixel store byte address
//  rd_data_i    in   8   pixel store data, valid 1 clk after rd_en_o
//  enc_valid_o  out  1   byte available for the encoder
//  enc_data_o   out  8   byte to encoder, MSB sent first
//  enc_ready_i  in   1   encoder accepts byte this cycle
//  enc_idle_i   in   1   encoder shift register empty, line low
//  busy_o       out  1   frame in progress (FETCH..LATCH)
//  frame_done_o out  1   one-cycle pulse when the latch gap ends
// BEHAVIOUR
//  - Single clock domain, one clock (clk); reset is asynchronous and active high (reset).
//  - Reset: state IDLE; all outputs 0; byte index 0; pending flag 0; latch counter 0.
//  - FSM: IDLE -> FETCH -> LOAD -> SEND -> (FETCH | DRAIN) -> LATCH -> (FETCH | IDLE).
//    IDLE:  upd_req_i=1 -> FETCH with idx=0.
//    FETCH: rd_en_o=1, rd_addr_o=idx; -> LOAD.
//    LOAD:  capture rd_data_i into enc_data_o; -> SEND.
//    SEND:  enc_valid_o=1, enc_data_o stable while enc_ready_i=0. Transfer = valid&ready at an edge;
//           idx<NBYTES-1 -> idx+1, FETCH; idx=NBYTES-1 -> DRAIN. enc_valid_o drops after transfer.
//    DRAIN: minimum one cycle; leave when enc_idle_i=1 -> LATCH, counter loaded with LATCH_CYCLES-1.
//    LATCH: count down to 0; at 0 pulse frame_done_o; pending=1 -> FETCH idx=0, clear pending; else IDLE.
//  - Latency: enc_valid_o rises 2 clks after the edge that samples upd_req_i in IDLE.
//  - Requests while busy_o=1 set pending; any number coalesce into exactly one follow-up frame.
//  - A request in the same cycle as frame_done_o is kept as pending (no frame lost).
//  - Byte addresses 0..NBYTES-1 in order; idx never wraps within a frame.
//  - busy_o=1 in every state except IDLE; frame_done_o=1 only in the final LATCH cycle.
//  - Reset mid-frame: immediate return to IDLE, enc_valid_o=0, pending cleared; the encoder shares reset.
// CONFIGURATION
//  AUTO_REFRESH_EN defined: free-running counter 0..REFRESH_CYCLES-1, wraps; wrap generates an
//   internal request ORed with upd_req_i (same pending rules). Counter runs from reset, independent
//   of the FSM.
//  AUTO_REFRESH_EN undefined: no counter logic; frames start only on upd_req_i.
// STRUCTURE
//  - Package led_pkg: state enum (IDLE,FETCH,LOAD,SEND,DRAIN,LATCH), BYTES_PER_LED default,
//    nbytes() and addr-width helper functions.
//  - Sub-module led_gap_timer: loadable down-counter with done flag, used for LATCH and,
//    when enabled, the auto-refresh period.
// TESTING
//  1 reset held, then released with no request -> all outputs 0, busy_o=0 indefinitely.
//  2 LED_CNT=10, encoder ready_i=1 after 24 clks per byte -> 30 transfers, addresses 0..29, data matches
//    store; frame_done_o pulses exactly LATCH_CYCLES clks after enc_idle_i rises.
//  3 three upd_req_i pulses during frame -> exactly one extra frame, starting in the cycle after frame_done_o.
//  4 enc_ready_i held 0 for 100 clks in SEND -> enc_valid_o=1, enc_data_o unchanged for all 100 clks.
//  5 reset asserted at byte 15 -> outputs 0 within same cycle (async); next upd_req_i restarts at addr 0.
//  6 AUTO_REFRESH_EN, REFRESH_CYCLES=5000, no upd_req_i -> frames start every 5000 clks; undefined -> none.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: state encoding and sizing helpers shared by the LED frame sequencer
package led_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DRAIN, LATCH} state_t;
    localparam int BPL_DEFAULT = 3;
    function automatic int nbytes(input int leds, input int bpl);
        return leds * bpl;
    endfunction
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/led_gap_timer.sv
// led_gap_timer: loadable down-counter with a zero flag
//   clk, reset  clock, asynchronous active-high reset (count returns to RST_VAL)
//   load        load load_val, takes priority over en
//   load_val    value to load
//   en          decrement while nonzero
//   done        count is zero
module led_gap_timer #(
    parameter int W = 12,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= RST_VAL;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    assign done = cnt == '0;
endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: walks the pixel byte store, feeds the bit encoder, drains and holds the latch gap
//   clk, reset            clock, asynchronous active-high reset
//   upd_req_i             one-cycle refresh request
//   rd_en_o, rd_addr_o    pixel store read port, rd_data_i valid one clk after rd_en_o
//   enc_valid_o/_data_o   byte handshake to encoder with enc_ready_i, enc_idle_i = line drained
//   busy_o, frame_done_o  frame in progress, one-cycle pulse at end of latch gap
//   AUTO_REFRESH_EN       when defined, a free-running REFRESH_CYCLES period adds its own requests
module led_frame_sequencer import led_pkg::*; #(
    parameter int LED_CNT       = 10,
    parameter int BYTES_PER_LED = BPL_DEFAULT,
    parameter int LATCH_CYCLES  = 3000
`ifdef AUTO_REFRESH_EN
    , parameter int REFRESH_CYCLES = 500000
`endif
    , localparam int NBYTES = nbytes(LED_CNT, BYTES_PER_LED)
    , localparam int AW     = addr_w(NBYTES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          upd_req_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [7:0]    rd_data_i,
    output logic          enc_valid_o,
    output logic [7:0]    enc_data_o,
    input  logic          enc_ready_i,
    input  logic          enc_idle_i,
    output logic          busy_o,
    output logic          frame_done_o
);
    localparam int LW = addr_w(LATCH_CYCLES);
    state_t state, state_n;
    logic [AW-1:0] idx;
    logic pending, req, latch_zero, last_byte, frame_end;
`ifdef AUTO_REFRESH_EN
    localparam int RW = addr_w(REFRESH_CYCLES);
    logic refresh_wrap;
    // first wrap lands REFRESH_CYCLES clocks after reset, then every REFRESH_CYCLES
    led_gap_timer #(.W(RW), .RST_VAL(RW'(REFRESH_CYCLES - 1))) u_refresh (
        .clk(clk), .reset(reset), .load(refresh_wrap), .load_val(RW'(REFRESH_CYCLES - 1)),
        .en(1'b1), .done(refresh_wrap)
    );
    assign req = upd_req_i | refresh_wrap;
`else
    assign req = upd_req_i;
`endif
    led_gap_timer #(.W(LW)) u_latch (
        .clk(clk), .reset(reset), .load(state == DRAIN && enc_idle_i),
        .load_val(LW'(LATCH_CYCLES - 1)), .en(state == LATCH), .done(latch_zero)
    );
    assign last_byte = idx == AW'(NBYTES - 1);
    assign frame_end = state == LATCH && latch_zero;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    // a request landing on frame_end is kept so it is not lost; IDLE consumes a leftover one
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            idx        <= '0;
            pending    <= 1'b0;
            enc_data_o <= '0;
        end else begin
            if (state == LOAD) enc_data_o <= rd_data_i;
            idx     <= (state == IDLE || state == LATCH) ? '0 :
                       (state == SEND && enc_ready_i && !last_byte) ? idx + 1'b1 : idx;
            pending <= (state == IDLE) ? 1'b0 : frame_end ? req : (pending | req);
        end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req || pending) state_n = FETCH;
            FETCH:   state_n = LOAD;
            LOAD:    state_n = SEND;
            SEND:    if (enc_ready_i) state_n = last_byte ? DRAIN : FETCH;
            DRAIN:   if (enc_idle_i) state_n = LATCH;
            LATCH:   if (latch_zero) state_n = pending ? FETCH : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        busy_o       = state != IDLE;
        rd_en_o      = state == FETCH;
        rd_addr_o    = (state == FETCH) ? idx : '0;
        enc_valid_o  = state == SEND;
        frame_done_o = frame_end;
    end
endmodule
